// File: rtl/lfsr_seq_ctrl_pkg.sv
// rtl/lfsr_seq_ctrl_pkg.sv - shared opcodes, FSM encoding and LFSR defaults
//
// Purpose: constants shared by the LFSR sequencer, its datapath core and
// anything driving its command port.
package lfsr_seq_ctrl_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_SKIP = 2'b10;
  localparam logic [1:0] OP_MEAS = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SKIP = 2'b10,
    ST_MEAS = 2'b11
  } fsm_state_t;

  // Defaults for a 4-bit register: x^4 + x^3 + 1, maximal period 15
  localparam logic [3:0] DEF_TAPS      = 4'b1100;
  localparam logic [3:0] DEF_SAFE_SEED = 4'b0001;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - command and word-stream handshake bundle
//
// Purpose: groups the command port (cmd_*) and the output word stream (out_*).
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_arg : host -> sequencer command
//   out_valid/out_ready/out_data       : sequencer -> consumer LFSR words
// Modports: master = host/consumer side, slave = sequencer side.
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, out_ready,
    input  cmd_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, out_ready,
    output cmd_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_seq_ctrl_lfsr_core.sv
// rtl/lfsr_seq_ctrl_lfsr_core.sv - Fibonacci LFSR state register
//
// Purpose: holds the LFSR state and applies the step function.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset (state <= SAFE_SEED)
//   load      : replace state with load_val (wins over step)
//   load_val  : value to load
//   step      : advance one position
//   state     : current register contents
//   nxt       : value the register would take on a step
module lfsr_core
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
  parameter logic [WIDTH-1:0] SAFE_SEED = DEF_SAFE_SEED
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt
);

  // Shift toward the MSB; the parity of the tapped bits enters at bit 0
  assign nxt = {state[WIDTH-2:0], ^(state & TAPS)};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SAFE_SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - command-driven sequencer around a Fibonacci LFSR
//
// Purpose: accepts LOAD / RUN / SKIP / MEASURE commands and drives the LFSR.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   bus        : slave side of lfsr_seq_ctrl_if (commands in, words out)
//   done       : one-cycle pulse when a command completes
//   period     : last measured period (held until the next MEASURE completes)
//   period_ovf : last MEASURE hit the counter limit without a match
//   seed_fix   : one-cycle pulse when a zero LOAD seed was replaced
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
  parameter logic [WIDTH-1:0] SAFE_SEED = DEF_SAFE_SEED,
  parameter int               CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  lfsr_seq_ctrl_if.slave   bus,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             period_ovf,
  output logic             seed_fix
);

  fsm_state_t       fsm, fsm_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] period_n;
  logic [WIDTH-1:0] start, start_n;
  logic [WIDTH-1:0] lfsr_q, lfsr_nxt, load_val;
  logic             load, step, done_n, fix_n, ovf_n;
  logic             accept;

  lfsr_core #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .SAFE_SEED (SAFE_SEED)
  ) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .state    (lfsr_q),
    .nxt      (lfsr_nxt)
  );

  assign bus.cmd_ready = (fsm == ST_IDLE) && !RST;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // The word on offer is always the pre-step state; it only moves on a
  // handshake, which keeps out_data stable under backpressure.
  assign bus.out_valid = (fsm == ST_RUN);
  assign bus.out_data  = lfsr_q;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm        <= ST_IDLE;
      rem        <= '0;
      cnt        <= '0;
      start      <= SAFE_SEED;
      done       <= 1'b0;
      seed_fix   <= 1'b0;
      period     <= '0;
      period_ovf <= 1'b0;
    end else begin
      fsm        <= fsm_n;
      rem        <= rem_n;
      cnt        <= cnt_n;
      start      <= start_n;
      done       <= done_n;
      seed_fix   <= fix_n;
      period     <= period_n;
      period_ovf <= ovf_n;
    end
  end

  always_comb begin
    fsm_n    = fsm;
    rem_n    = rem;
    cnt_n    = cnt;
    start_n  = start;
    period_n = period;
    ovf_n    = period_ovf;
    done_n   = 1'b0;
    fix_n    = 1'b0;
    load     = 1'b0;
    load_val = bus.cmd_arg[WIDTH-1:0];
    step     = 1'b0;

    case (fsm)
      ST_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              load   = 1'b1;
              done_n = 1'b1;
              // All-zero is the LFSR's lock-up state
              if (bus.cmd_arg[WIDTH-1:0] == '0) begin
                load_val = SAFE_SEED;
                fix_n    = 1'b1;
              end
            end
            OP_RUN, OP_SKIP: begin
              if (bus.cmd_arg == '0) begin
                done_n = 1'b1;
              end else begin
                rem_n = bus.cmd_arg;
                fsm_n = (bus.cmd_op == OP_RUN) ? ST_RUN : ST_SKIP;
              end
            end
            default: begin
              start_n = lfsr_q;
              cnt_n   = '0;
              fsm_n   = ST_MEAS;
            end
          endcase
        end
      end

      ST_RUN: begin
        if (bus.out_ready) begin
          step  = 1'b1;
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            fsm_n  = ST_IDLE;
            done_n = 1'b1;
          end
        end
      end

      ST_SKIP: begin
        step  = 1'b1;
        rem_n = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          fsm_n  = ST_IDLE;
          done_n = 1'b1;
        end
      end

      ST_MEAS: begin
        step  = 1'b1;
        cnt_n = cnt_inc;
        // A match leaves the register back at start, since this step lands on it
        if (lfsr_nxt == start) begin
          period_n = cnt_inc;
          ovf_n    = 1'b0;
          done_n   = 1'b1;
          fsm_n    = ST_IDLE;
        end else if (cnt_inc == '1) begin
          period_n = '1;
          ovf_n    = 1'b1;
          done_n   = 1'b1;
          fsm_n    = ST_IDLE;
        end
      end

      default: fsm_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - scoreboard testbench for lfsr_seq_ctrl
module tb_lfsr_seq_ctrl;
  import lfsr_seq_ctrl_pkg::*;

  localparam logic [3:0] M_TAPS = 4'b1100;
  localparam logic [3:0] M_SAFE = 4'b0001;

  typedef struct {
    logic       fix;
    logic [7:0] per;
    logic       ovf;
  } done_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       done, period_ovf, seed_fix;
  logic [7:0] period;

  lfsr_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

  lfsr_seq_ctrl #(
    .WIDTH(4), .TAPS(4'b1100), .SAFE_SEED(4'b0001), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .done(done),
    .period(period), .period_ovf(period_ovf), .seed_fix(seed_fix)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_q[$];
  done_t      done_q[$];
  bit         pat_q[$];
  bit         pend_q[$];
  bit         rnd_rdy = 0;
  bit         hold_low = 0;
  int         hs_cnt = 0;

  logic [3:0] m_state;
  logic [7:0] m_per;
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Reference: shift left within 4 bits, new LSB = parity of tapped bits
  function automatic logic [3:0] m_step(input logic [3:0] s);
    int fb;
    int v;
    fb = $countones(s & M_TAPS) % 2;
    v  = ((int'(s) * 2) % 16) + fb;
    return v[3:0];
  endfunction

  function automatic void m_measure(input logic [3:0] s, output logic [7:0] p, output logic o);
    logic [3:0] x;
    x = s;
    for (int k = 1; k <= 255; k++) begin
      x = m_step(x);
      if (x == s) begin
        p = 8'(k);
        o = 1'b0;
        return;
      end
    end
    p = 8'hFF;
    o = 1'b1;
  endfunction

  // out_ready driver: forced low, scripted pattern, random, or held high
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (hold_low) bus.out_ready = 1'b0;
      else if (pat_q.size() > 0) bus.out_ready = pat_q.pop_front();
      else if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: pops expected words and completions as the DUT presents them
  bit         stalled_prev = 0;
  logic [3:0] prev_data = '0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.out_valid) begin
        if (stalled_prev) check("stall_hold", 32'(bus.out_data), 32'(prev_data));
        if (exp_q.size() == 0) fail("spurious_out_valid");
        else if (bus.out_ready) begin
          check("word", 32'(bus.out_data), 32'(exp_q.pop_front()));
          hs_cnt++;
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          check("seed_fix", 32'(seed_fix), 32'(d.fix));
          check("period", 32'(period), 32'(d.per));
          check("period_ovf", 32'(period_ovf), 32'(d.ovf));
        end
      end else if (seed_fix) begin
        fail("seed_fix_without_done");
      end
    end
    stalled_prev = bus.out_valid && !bus.out_ready;
    prev_data    = bus.out_data;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg, input bit wait_done,
                          output int lat);
    int         k;
    logic [3:0] seed;
    done_t      d;
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    k = 0;
    while (!bus.cmd_ready && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.cmd_ready) begin
      fail("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      lat = -1;
      return;
    end
    d.fix = 1'b0;
    case (op)
      OP_LOAD: begin
        seed = arg[3:0];
        if (seed == 4'b0000) begin
          seed  = M_SAFE;
          d.fix = 1'b1;
        end
        m_state = seed;
      end
      OP_RUN: begin
        for (int i = 0; i < int'(arg); i++) begin
          exp_q.push_back(m_state);
          m_state = m_step(m_state);
        end
      end
      OP_SKIP: begin
        for (int i = 0; i < int'(arg); i++) m_state = m_step(m_state);
      end
      default: m_measure(m_state, m_per, m_ovf);
    endcase
    d.per = m_per;
    d.ovf = m_ovf;
    done_q.push_back(d);
    @(posedge CLK);
    pat_q = pend_q;
    pend_q.delete();
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    if (wait_done) begin
      do begin
        @(negedge CLK);
        lat++;
      end while (!done && lat < 600);
      if (!done) fail("done_timeout");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int k;
    logic [1:0] op;
    logic [7:0] arg;

    RST = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_arg = '0;
    m_state = M_SAFE;
    m_per = '0;
    m_ovf = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_period", 32'(period), 0);
    check("rst_period_ovf", 32'(period_ovf), 0);
    check("rst_seed_fix", 32'(seed_fix), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // 1: LOAD 0001, RUN 5 at full throughput
    send_cmd(OP_LOAD, 8'h01, 1, lat);
    check("load_latency", 32'(lat), 1);
    send_cmd(OP_RUN, 8'd5, 1, lat);
    check("run5_latency", 32'(lat), 6);
    check("run5_cmd_ready", 32'(bus.cmd_ready), 1);

    // 2: zero seed replaced by SAFE_SEED
    send_cmd(OP_LOAD, 8'h00, 1, lat);
    send_cmd(OP_RUN, 8'd1, 1, lat);

    // 3: backpressure pattern
    send_cmd(OP_LOAD, 8'h01, 1, lat);
    pend_q = '{1, 0, 0, 1, 0, 1, 1};
    send_cmd(OP_RUN, 8'd4, 1, lat);
    check("run4_stall_latency", 32'(lat), 8);

    // 4: MEASURE from 0110 returns to start
    send_cmd(OP_LOAD, 8'h06, 1, lat);
    send_cmd(OP_MEAS, 8'h00, 1, lat);
    check("meas_latency", 32'(lat), 16);
    send_cmd(OP_RUN, 8'd1, 1, lat);

    // 5: SKIP then RUN, and zero-count commands
    send_cmd(OP_LOAD, 8'h01, 1, lat);
    send_cmd(OP_SKIP, 8'd3, 1, lat);
    check("skip3_latency", 32'(lat), 4);
    send_cmd(OP_RUN, 8'd1, 1, lat);
    send_cmd(OP_RUN, 8'd0, 1, lat);
    check("run0_latency", 32'(lat), 1);
    send_cmd(OP_SKIP, 8'd0, 1, lat);
    check("skip0_latency", 32'(lat), 1);

    // 6: reset in the middle of RUN 10
    send_cmd(OP_LOAD, 8'h01, 1, lat);
    base = hs_cnt;
    send_cmd(OP_RUN, 8'd10, 0, lat);
    k = 0;
    while (hs_cnt < base + 3 && k < 100) begin
      @(posedge CLK);
      k++;
    end
    if (hs_cnt < base + 3) fail("abort_handshake_timeout");
    #2;
    RST = 1'b1;
    hold_low = 1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    check("abort_cmd_ready_in_rst", 32'(bus.cmd_ready), 0);
    @(posedge CLK);
    exp_q.delete();
    done_q.delete();
    m_state = M_SAFE;
    m_per = '0;
    m_ovf = 1'b0;
    @(negedge CLK);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_done", 32'(done), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    hold_low = 0;
    @(negedge CLK);
    check("abort_cmd_ready_after", 32'(bus.cmd_ready), 1);
    send_cmd(OP_RUN, 8'd1, 1, lat);

    // Randomized command mix with random backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        OP_LOAD: arg = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15) << 4)
                                                   : 8'($urandom_range(0, 255));
        OP_RUN:  arg = 8'($urandom_range(0, 7));
        OP_SKIP: arg = 8'($urandom_range(0, 20));
        default: arg = 8'($urandom_range(0, 255));
      endcase
      send_cmd(op, arg, 1, lat);
      if (op == OP_LOAD) check("rnd_load_latency", 32'(lat), 1);
      if (op == OP_SKIP) check("rnd_skip_latency", 32'(lat), 32'(int'(arg) + 1));
      if (op == OP_MEAS) check("rnd_meas_latency", 32'(lat), 32'(int'(m_per) + 1));
    end
    rnd_rdy = 0;

    repeat (4) @(negedge CLK);
    check("words_left", 32'(exp_q.size()), 0);
    check("dones_left", 32'(done_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Command-driven sequencer for a Fibonacci LFSR. It accepts commands over a valid/ready port: load seed, emit N words, skip N steps, or measure the sequence period. Generated words stream out on a valid/ready port. The block sits between a host or test controller and the LFSR datapath; it owns the LFSR state register and is the only block that advances it.

Parameters:
- WIDTH, 4, LFSR register width in bits.
- TAPS, 4'b1100, feedback mask; bit i set means state[i] feeds the XOR. Default polynomial is x^4+x^3+1, period 15.
- SAFE_SEED, 4'b0001, value loaded at reset and in place of an all-zero seed.
- CNT_W, 8, width of the command argument and the period counter. Must satisfy CNT_W >= WIDTH.

Ports:
- CLK  in  1  sole clock; all logic acts on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  opcode: 00 LOAD, 01 RUN, 10 SKIP, 11 MEASURE.
- cmd_arg  in  CNT_W  seed (LOAD uses the low WIDTH bits) or step count (RUN/SKIP); ignored for MEASURE.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  LFSR state word.
- done  out  1  one-cycle pulse when a command completes.
- period  out  CNT_W  last measured period; holds until the next MEASURE completes.
- period_ovf  out  1  last MEASURE timed out.
- seed_fix  out  1  one-cycle pulse when a LOAD seed of zero was replaced by SAFE_SEED.

Behaviour:
- Step function: next = {state[WIDTH-2:0], ^(state & TAPS)}.
- Reset behaviour, applied at the first rising edge with RST high:
  - state = SAFE_SEED; FSM goes to IDLE.
  - out_valid, done, seed_fix, period_ovf = 0; period = 0.
  - cmd_ready = 0 while RST is high.
- cmd_ready = (fsm==IDLE) && !RST, combinational. Only one command is in flight at a time.
- FSM states: IDLE, RUN, SKIP, MEAS.
- LOAD:
  - Completes in IDLE on the accept edge: state <= cmd_arg[WIDTH-1:0].
  - A zero seed is replaced by SAFE_SEED and seed_fix pulses.
  - done pulses on the next cycle. FSM stays in IDLE.
- RUN, n = cmd_arg:
  - n = 0: done pulses the next cycle, no output, FSM stays in IDLE.
  - Otherwise enter RUN with remaining count = n. out_valid = 1 and out_data = current state.
  - On each out_valid && out_ready: state steps and remaining decrements.
  - The word emitted is the pre-step state. The first word is the state at accept.
  - out_valid never drops without acceptance (stall-stable).
  - After the n-th handshake: out_valid = 0 the next cycle, done pulses, return to IDLE.
  - Throughput is 1 word per cycle with out_ready held high.
- SKIP, n = cmd_arg:
  - One step per cycle, n cycles, no output. Then done pulses and return to IDLE.
  - n = 0 behaves like RUN with n = 0.
- MEAS:
  - Capture start = state and counter = 0.
  - Each cycle: step once and increment the counter.
  - When the stepped value equals start: period <= counter value including this step, period_ovf <= 0, done pulses, return to IDLE.
  - If the counter reaches 2^CNT_W-1 without a match: period <= all ones, period_ovf <= 1, done pulses, return to IDLE.
  - The LFSR is left at start on a match and at the stepped value on timeout.
- RST asserted mid-command aborts it: no done pulse, and out_valid drops at that edge.
- Latency: accept to first out_valid = 1 cycle. Last handshake to done = 1 cycle.

Decomposition:
- Shared package:
  - opcode constants OP_LOAD, OP_RUN, OP_SKIP, OP_MEAS;
  - FSM state encoding;
  - default TAPS and SAFE_SEED for WIDTH = 4.
- One natural sub-module, lfsr_core:
  - inputs: CLK, RST, load, load_val, step;
  - output: state;
  - contains the step function.
- The controller holds the FSM, counters and handshakes.

Test Plan:
1. Reset, then LOAD 0001, then RUN 5 with out_ready = 1. Required out_data sequence: 0001, 0010, 0100, 1001, 0011. Then a single done pulse and cmd_ready = 1.
2. LOAD 0000. Required: seed_fix pulses and state = 0001. A following RUN 1 must emit 0001.
3. LOAD 0001, then RUN 4 with out_ready toggling 1,0,0,1,0,1,1. Required: out_data holds stable while stalled, exactly 4 words 0001, 0010, 0100, 1001, no duplicates.
4. LOAD 0110, then MEASURE. Required: period = 15, period_ovf = 0, done after 15 step cycles, and a subsequent RUN 1 emits 0110.
5. LOAD 0001, SKIP 3, RUN 1. Required: emits 1001. Also check that RUN 0 and SKIP 0 give done one cycle after accept with out_valid never asserted.
6. RUN 10 with RST pulsed after 3 handshakes. Required: out_valid = 0 and no done pulse. After release, cmd_ready = 1 and the next RUN 1 emits 0001.
